// File: rtl/eater_pkg.sv
// eater_pkg: shared constants for the breadboard CPU microcode sequencer.
//   - bit positions of the 16 control lines and the matching one-hot masks
//   - opcode encodings (IR upper nibble)
//   - the two fetch control words, common to every instruction
package eater_pkg;

  localparam int unsigned CW_W = 16;

  // Control line bit positions
  localparam int unsigned B_HLT = 15;
  localparam int unsigned B_MI  = 14;
  localparam int unsigned B_RI  = 13;
  localparam int unsigned B_RO  = 12;
  localparam int unsigned B_IO  = 11;
  localparam int unsigned B_II  = 10;
  localparam int unsigned B_AI  = 9;
  localparam int unsigned B_AO  = 8;
  localparam int unsigned B_EO  = 7;
  localparam int unsigned B_SU  = 6;
  localparam int unsigned B_BI  = 5;
  localparam int unsigned B_OI  = 4;
  localparam int unsigned B_CE  = 3;
  localparam int unsigned B_CO  = 2;
  localparam int unsigned B_J   = 1;
  localparam int unsigned B_FI  = 0;

  // One-hot masks derived from the bit positions
  localparam logic [CW_W-1:0] M_HLT = 16'h0001 << B_HLT;
  localparam logic [CW_W-1:0] M_MI  = 16'h0001 << B_MI;
  localparam logic [CW_W-1:0] M_RI  = 16'h0001 << B_RI;
  localparam logic [CW_W-1:0] M_RO  = 16'h0001 << B_RO;
  localparam logic [CW_W-1:0] M_IO  = 16'h0001 << B_IO;
  localparam logic [CW_W-1:0] M_II  = 16'h0001 << B_II;
  localparam logic [CW_W-1:0] M_AI  = 16'h0001 << B_AI;
  localparam logic [CW_W-1:0] M_AO  = 16'h0001 << B_AO;
  localparam logic [CW_W-1:0] M_EO  = 16'h0001 << B_EO;
  localparam logic [CW_W-1:0] M_SU  = 16'h0001 << B_SU;
  localparam logic [CW_W-1:0] M_BI  = 16'h0001 << B_BI;
  localparam logic [CW_W-1:0] M_OI  = 16'h0001 << B_OI;
  localparam logic [CW_W-1:0] M_CE  = 16'h0001 << B_CE;
  localparam logic [CW_W-1:0] M_CO  = 16'h0001 << B_CO;
  localparam logic [CW_W-1:0] M_J   = 16'h0001 << B_J;
  localparam logic [CW_W-1:0] M_FI  = 16'h0001 << B_FI;

  // Opcodes (9..D are unassigned and decode as NOP)
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Fetch control words: T0 = CO|MI, T1 = RO|II|CE
  localparam logic [CW_W-1:0] CW_T0 = 16'h4004;
  localparam logic [CW_W-1:0] CW_T1 = 16'h1408;

endpackage

// File: rtl/eater_ucode_rom.sv
// eater_ucode_rom: combinational microcode decoder.
//   i_opcode [3:0]  current opcode
//   i_step   [2:0]  current microstep
//   i_carry, i_zero ALU flags (only consulted at T2 of JC/JZ)
//   o_ctrl   [15:0] control word for this step
//   o_last          this step is the final one of the instruction
// Steps past an opcode's last step, and illegal steps 5..7, yield ctrl=0
// with o_last=1 so the counter recovers to T0 on the next enabled edge.
module eater_ucode_rom
  import eater_pkg::*;
(
  input  logic [3:0]      i_opcode,
  input  logic [2:0]      i_step,
  input  logic            i_carry,
  input  logic            i_zero,
  output logic [CW_W-1:0] o_ctrl,
  output logic            o_last
);

  // Decode (opcode, step, flags) into the control word and last-step flag
  always_comb begin
    o_ctrl = 16'h0000;
    o_last = 1'b1;
    case (i_step)
      3'd0: begin
        o_ctrl = CW_T0;
        o_last = 1'b0;
      end
      3'd1: begin
        o_ctrl = CW_T1;
        o_last = 1'b0;
      end
      3'd2: begin
        case (i_opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            o_ctrl = M_IO | M_MI;
            o_last = 1'b0;
          end
          OP_LDI: o_ctrl = M_IO | M_AI;
          OP_JMP: o_ctrl = M_IO | M_J;
          // Untaken conditional jumps still spend T2 as an idle step
          OP_JC: begin
            if (i_carry) o_ctrl = M_IO | M_J;
            else         o_ctrl = 16'h0000;
          end
          OP_JZ: begin
            if (i_zero) o_ctrl = M_IO | M_J;
            else        o_ctrl = 16'h0000;
          end
          OP_OUT:  o_ctrl = M_AO | M_OI;
          OP_HLT:  o_ctrl = M_HLT;
          default: o_ctrl = 16'h0000;
        endcase
      end
      3'd3: begin
        case (i_opcode)
          OP_LDA: o_ctrl = M_RO | M_AI;
          OP_ADD, OP_SUB: begin
            o_ctrl = M_RO | M_BI;
            o_last = 1'b0;
          end
          OP_STA:  o_ctrl = M_AO | M_RI;
          default: o_ctrl = 16'h0000;
        endcase
      end
      3'd4: begin
        case (i_opcode)
          OP_ADD:  o_ctrl = M_EO | M_AI | M_FI;
          OP_SUB:  o_ctrl = M_EO | M_SU | M_AI | M_FI;
          default: o_ctrl = 16'h0000;
        endcase
      end
      default: begin
        o_ctrl = 16'h0000;
        o_last = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/eater_ctrl_seq.sv
// eater_ctrl_seq: microcode sequencer for the 8-bit breadboard CPU.
//   clk     system clock
//   clr     asynchronous active-high reset
//   run     run enable; 0 freezes the step counter and masks ctrl
//   opcode  instruction-register upper nibble (no internal copy is kept)
//   carry   registered ALU carry flag
//   zero    registered ALU zero flag
//   ctrl    16-bit control word, combinational from registered state
//   step    current microstep
//   halted  set by HLT, cleared only by clr
module eater_ctrl_seq
  import eater_pkg::*;
#(
  parameter int OPW = 4,
  parameter int STW = 3
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           run,
  input  logic [OPW-1:0] opcode,
  input  logic           carry,
  input  logic           zero,
  output logic [15:0]    ctrl,
  output logic [STW-1:0] step,
  output logic           halted
);

  logic [STW-1:0]  r_step;
  logic            r_halted;
  logic [CW_W-1:0] w_rom_ctrl;
  logic            w_last;

  eater_ucode_rom u_rom (
    .i_opcode (opcode),
    .i_step   (r_step),
    .i_carry  (carry),
    .i_zero   (zero),
    .o_ctrl   (w_rom_ctrl),
    .o_last   (w_last)
  );

  // Step counter and halt latch; both frozen when run is low or halted
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_step   <= '0;
      r_halted <= 1'b0;
    end else if (run && !r_halted) begin
      if (w_last) r_step <= '0;
      else        r_step <= r_step + STW'(1);
      if ((r_step == STW'(2)) && (opcode == OP_HLT)) r_halted <= 1'b1;
      else                                            r_halted <= r_halted;
    end else begin
      r_step   <= r_step;
      r_halted <= r_halted;
    end
  end

  // Output masking: halt dominates, then the run gate, then the decoder
  always_comb begin
    ctrl = 16'h0000;
    if (r_halted)  ctrl = M_HLT;
    else if (!run) ctrl = 16'h0000;
    else           ctrl = w_rom_ctrl;
  end

  assign step   = r_step;
  assign halted = r_halted;

endmodule

// File: tb/tb_eater_ctrl_seq.sv
// Directed self-checking bench for eater_ctrl_seq.
module tb_eater_ctrl_seq;

  logic        clk;
  logic        clr;
  logic        run;
  logic [3:0]  opcode;
  logic        carry;
  logic        zero;
  logic [15:0] ctrl;
  logic [2:0]  step;
  logic        halted;

  int checks;
  int failures;

  eater_ctrl_seq dut (
    .clk    (clk),
    .clr    (clr),
    .run    (run),
    .opcode (opcode),
    .carry  (carry),
    .zero   (zero),
    .ctrl   (ctrl),
    .step   (step),
    .halted (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [15:0] ectrl,
                           input logic [2:0] estep, input logic ehalt);
    chk({tag, ".ctrl"}, ctrl, ectrl);
    chk({tag, ".step"}, {13'd0, step}, {13'd0, estep});
    chk({tag, ".halted"}, {15'd0, halted}, {15'd0, ehalt});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clr    = 1'b1;
    run    = 1'b1;
    opcode = 4'h2;
    carry  = 1'b0;
    zero   = 1'b0;

    // 1: reset, then a full ADD
    #2;
    chk_state("rst", 16'h4004, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk_state("add.t0", 16'h4004, 3'd0, 1'b0);
    tick(1); chk_state("add.t1", 16'h1408, 3'd1, 1'b0);
    tick(1); chk_state("add.t2", 16'h4800, 3'd2, 1'b0);
    tick(1); chk_state("add.t3", 16'h1020, 3'd3, 1'b0);
    tick(1); chk_state("add.t4", 16'h0281, 3'd4, 1'b0);
    tick(1); chk_state("add.end", 16'h4004, 3'd0, 1'b0);

    // 2: SUB and LDI
    opcode = 4'h3;
    tick(4); chk_state("sub.t4", 16'h02C1, 3'd4, 1'b0);
    tick(1); chk_state("sub.end", 16'h4004, 3'd0, 1'b0);
    opcode = 4'h5;
    tick(2); chk_state("ldi.t2", 16'h0A00, 3'd2, 1'b0);
    tick(1); chk_state("ldi.end", 16'h4004, 3'd0, 1'b0);

    // Other opcodes
    opcode = 4'h1;
    tick(3); chk_state("lda.t3", 16'h1200, 3'd3, 1'b0);
    tick(1); chk_state("lda.end", 16'h4004, 3'd0, 1'b0);
    opcode = 4'h4;
    tick(2); chk_state("sta.t2", 16'h4800, 3'd2, 1'b0);
    tick(1); chk_state("sta.t3", 16'h2100, 3'd3, 1'b0);
    tick(1); chk_state("sta.end", 16'h4004, 3'd0, 1'b0);
    opcode = 4'hE;
    tick(2); chk_state("out.t2", 16'h0110, 3'd2, 1'b0);
    tick(1); chk_state("out.end", 16'h4004, 3'd0, 1'b0);
    opcode = 4'h6;
    tick(2); chk_state("jmp.t2", 16'h0802, 3'd2, 1'b0);
    tick(1); chk_state("jmp.end", 16'h4004, 3'd0, 1'b0);
    opcode = 4'hA;
    tick(2); chk_state("undef.t2", 16'h0000, 3'd2, 1'b0);
    tick(1); chk_state("undef.end", 16'h4004, 3'd0, 1'b0);
    opcode = 4'h0;
    tick(2); chk_state("nop.t2", 16'h0000, 3'd2, 1'b0);
    tick(1); chk_state("nop.end", 16'h4004, 3'd0, 1'b0);

    // 3: conditional jumps
    opcode = 4'h7; carry = 1'b0; zero = 1'b1;
    tick(2); chk_state("jc0.t2", 16'h0000, 3'd2, 1'b0);
    tick(1); chk_state("jc0.end", 16'h4004, 3'd0, 1'b0);
    carry = 1'b1; zero = 1'b0;
    tick(2); chk_state("jc1.t2", 16'h0802, 3'd2, 1'b0);
    tick(1); chk_state("jc1.end", 16'h4004, 3'd0, 1'b0);
    opcode = 4'h8; carry = 1'b1; zero = 1'b0;
    tick(2); chk_state("jz0.t2", 16'h0000, 3'd2, 1'b0);
    tick(1); chk_state("jz0.end", 16'h4004, 3'd0, 1'b0);
    carry = 1'b0; zero = 1'b1;
    tick(2); chk_state("jz1.t2", 16'h0802, 3'd2, 1'b0);
    tick(1); chk_state("jz1.end", 16'h4004, 3'd0, 1'b0);
    zero = 1'b0;

    // 4: HLT latch, immune to run/opcode/flags, cleared by clr
    opcode = 4'hF;
    tick(2); chk_state("hlt.t2", 16'h8000, 3'd2, 1'b0);
    tick(1); chk_state("hlt.latched", 16'h8000, 3'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      run    = i[0];
      opcode = 4'(i);
      carry  = i[1];
      zero   = i[2];
      tick(1);
      chk_state("hlt.hold", 16'h8000, 3'd0, 1'b1);
    end
    run = 1'b1; opcode = 4'h2; carry = 1'b0; zero = 1'b0;
    clr = 1'b1;
    #1;
    chk_state("hlt.clr", 16'h4004, 3'd0, 1'b0);
    clr = 1'b0;
    tick(1); chk_state("post_clr.t1", 16'h1408, 3'd1, 1'b0);
    tick(4); chk_state("post_clr.end", 16'h4004, 3'd0, 1'b0);

    // 5: run dropped at step 3 of ADD
    tick(3); chk_state("pause.t3", 16'h1020, 3'd3, 1'b0);
    run = 1'b0;
    #1;
    chk_state("pause.mask", 16'h0000, 3'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk_state("pause.hold", 16'h0000, 3'd3, 1'b0);
    end
    run = 1'b1;
    #1;
    chk_state("pause.resume", 16'h1020, 3'd3, 1'b0);
    tick(1); chk_state("pause.t4", 16'h0281, 3'd4, 1'b0);
    tick(1); chk_state("pause.end", 16'h4004, 3'd0, 1'b0);

    // 6: async clr in the middle of ADD T4
    tick(4); chk_state("aclr.t4", 16'h0281, 3'd4, 1'b0);
    #2;
    clr = 1'b1;
    #1;
    chk_state("aclr.now", 16'h4004, 3'd0, 1'b0);
    tick(1); chk_state("aclr.held", 16'h4004, 3'd0, 1'b0);
    clr = 1'b0;
    tick(1); chk_state("aclr.t1", 16'h1408, 3'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
